// File: rtl/mcpu_core_stage_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mcpu_core_stage_mem_pipe                                     |
// | Description : Pipelined memory stage. Shapes B/H/W/D loads and stores for  |
// |               the data cache, tracks up to DEPTH requests in flight,       |
// |               extracts and extends load data, and completes in order.      |
// |               Optional feature macro: MCPU_MEM_MISALIGN_FAULT_EN (reports  |
// |               misaligned H/W/D accesses as faults, no cache request).      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mcpu_core_stage_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int RD_W   = 5
) (
    input  logic                               clkrst_core_clk,
    input  logic                               clkrst_core_rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ADDR_W-1:0]                  in_paddr,
    input  logic [DATA_W-1:0]                  in_data,
    input  logic [3:0]                         in_type,
    input  logic [RD_W-1:0]                    in_rd_num,
    input  logic                               in_rd_we,
    input  logic                               flush,
    output logic                               dc_req_valid,
    input  logic                               dc_req_ready,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0] dc_req_addr,
    output logic [DATA_W/8-1:0]                dc_req_wmask,
    output logic [DATA_W-1:0]                  dc_req_wdata,
    input  logic                               dc_resp_valid,
    input  logic [DATA_W-1:0]                  dc_resp_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_W-1:0]                  out_data,
    output logic [RD_W-1:0]                    out_rd_num,
    output logic                               out_rd_we,
    output logic                               out_fault
);

    localparam int C_NB    = DATA_W / 8;
    localparam int C_OFF_W = $clog2(C_NB);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;

    // A doubleword on a 32-bit cache behaves exactly like a word.
    function automatic logic [1:0] f_eff_size(input logic [1:0] sz);
        return (sz == 2'd3 && DATA_W == 32) ? 2'd2 : sz;
    endfunction

    // Pull the addressed lanes down to bit 0, then zero- or sign-extend by size.
    function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] raw,
                                                    input logic [3:0]        typ,
                                                    input logic [C_OFF_W-1:0] off);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic              sb;
        sh = raw >> {off, 3'b000};
        case (f_eff_size(typ[1:0]))
            2'd0:    begin keep = DATA_W'(64'hFF);        sb = sh[7];  end
            2'd1:    begin keep = DATA_W'(64'hFFFF);      sb = sh[15]; end
            2'd2:    begin keep = DATA_W'(64'hFFFF_FFFF); sb = sh[31]; end
            default: begin keep = '1;                     sb = 1'b0;   end
        endcase
        return (sh & keep) | ((typ[3] & sb) ? ~keep : '0);
    endfunction

    // Tracking entries, indexed by the alloc / retire pointers.
    logic [3:0]         type_q   [DEPTH];
    logic [3:0]         type_d   [DEPTH];
    logic [C_OFF_W-1:0] off_q    [DEPTH];
    logic [C_OFF_W-1:0] off_d    [DEPTH];
    logic [RD_W-1:0]    rd_num_q [DEPTH];
    logic [RD_W-1:0]    rd_num_d [DEPTH];
    logic               rd_we_q  [DEPTH];
    logic               rd_we_d  [DEPTH];
    logic               killed_q [DEPTH];
    logic               killed_d [DEPTH];
    logic               filled_q [DEPTH];
    logic               filled_d [DEPTH];
    logic               fault_q  [DEPTH];
    logic               fault_d  [DEPTH];
    logic [DATA_W-1:0]  data_q   [DEPTH];
    logic [DATA_W-1:0]  data_d   [DEPTH];
    logic [C_PTR_W-1:0] alloc_q, alloc_d;
    logic [C_PTR_W-1:0] retire_q, retire_d;
    logic [C_CNT_W-1:0] count_q, count_d;

    logic [1:0]         w_size;
    logic [C_OFF_W-1:0] w_size_lsb_mask;
    logic [C_OFF_W-1:0] w_aligned_off;
    logic [C_NB-1:0]    w_mask_base;
    logic               w_misalign;
    logic               w_full;
    logic               w_accept;
    logic               w_head_filled;
    logic               w_retire;
    logic               w_found;
    logic [C_PTR_W-1:0] w_resp_idx;
    logic               w_fill;

    // Request shaping: natural-alignment mask of the low address bits and lane mask.
    always_comb begin
        w_size = f_eff_size(in_type[1:0]);
        case (w_size)
            2'd0:    begin w_size_lsb_mask = '0;            w_mask_base = C_NB'(1);  end
            2'd1:    begin w_size_lsb_mask = C_OFF_W'(1);   w_mask_base = C_NB'(3);  end
            2'd2:    begin w_size_lsb_mask = C_OFF_W'(3);   w_mask_base = C_NB'(15); end
            default: begin w_size_lsb_mask = C_OFF_W'(7);   w_mask_base = '1;        end
        endcase
        w_aligned_off = in_paddr[C_OFF_W-1:0] & ~w_size_lsb_mask;
    end

`ifdef MCPU_MEM_MISALIGN_FAULT_EN
    assign w_misalign = in_type[1:0] != 2'd0 && (in_paddr[C_OFF_W-1:0] & w_size_lsb_mask) != '0;
    assign out_fault  = out_valid & fault_q[retire_q];
`else
    assign w_misalign = 1'b0;
    assign out_fault  = 1'b0;
`endif

    // A faulting access needs no cache slot, so it does not wait on dc_req_ready.
    assign w_full       = count_q == C_CNT_W'(DEPTH);
    assign in_ready     = ~clkrst_core_rst & (dc_req_ready | w_misalign) & ~w_full & ~flush;
    assign dc_req_valid = ~clkrst_core_rst & in_valid & ~w_full & ~flush & ~w_misalign;
    assign w_accept     = in_valid & in_ready;
    assign dc_req_addr  = in_paddr[ADDR_W-1:C_OFF_W];
    assign dc_req_wmask = in_type[2] ? (w_mask_base << w_aligned_off) : '0;
    assign dc_req_wdata = in_data << {w_aligned_off, 3'b000};

    // Head of the FIFO: deliver live results, drop killed ones without a handshake.
    assign w_head_filled = (count_q != '0) & filled_q[retire_q];
    assign out_valid     = w_head_filled & ~killed_q[retire_q];
    assign w_retire      = w_head_filled & (killed_q[retire_q] | out_ready);
    assign out_data      = out_valid ? data_q[retire_q] : '0;
    assign out_rd_num    = rd_num_q[retire_q];
    assign out_rd_we     = out_valid & rd_we_q[retire_q] & ~fault_q[retire_q];

    // Response pointer: oldest allocated entry still awaiting data (pre-filled faults are skipped).
    always_comb begin
        w_found    = 1'b0;
        w_resp_idx = retire_q;
        for (int i = 0; i < DEPTH; i++) begin
            logic [C_PTR_W-1:0] idx;
            idx = retire_q + C_PTR_W'(i);
            if (!w_found && (C_CNT_W'(i) < count_q) && !filled_q[idx]) begin
                w_found    = 1'b1;
                w_resp_idx = idx;
            end
        end
    end
    assign w_fill = dc_resp_valid & w_found;

    // Next state of the tracking FIFO: kill, fill, allocate and retire.
    always_comb begin
        type_d   = type_q;
        off_d    = off_q;
        rd_num_d = rd_num_q;
        rd_we_d  = rd_we_q;
        killed_d = killed_q;
        filled_d = filled_q;
        fault_d  = fault_q;
        data_d   = data_q;
        alloc_d  = alloc_q;
        retire_d = retire_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) killed_d[i] = 1'b1;
        end
        if (w_fill) begin
            filled_d[w_resp_idx] = 1'b1;
            data_d[w_resp_idx]   = type_q[w_resp_idx][2] ? '0
                                 : f_extract(dc_resp_data, type_q[w_resp_idx], off_q[w_resp_idx]);
        end
        if (w_accept) begin
            type_d[alloc_q]   = in_type;
            off_d[alloc_q]    = w_aligned_off;
            rd_num_d[alloc_q] = in_rd_num;
            rd_we_d[alloc_q]  = in_rd_we & ~in_type[2] & ~w_misalign;
            killed_d[alloc_q] = 1'b0;
            filled_d[alloc_q] = w_misalign;
            fault_d[alloc_q]  = w_misalign;
            data_d[alloc_q]   = '0;
            alloc_d           = alloc_q + C_PTR_W'(1);
        end
        if (w_retire) retire_d = retire_q + C_PTR_W'(1);
        count_d = count_q + C_CNT_W'(w_accept) - C_CNT_W'(w_retire);
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= '0;
                off_q[i]    <= '0;
                rd_num_q[i] <= '0;
                rd_we_q[i]  <= 1'b0;
                killed_q[i] <= 1'b0;
                filled_q[i] <= 1'b0;
                fault_q[i]  <= 1'b0;
                data_q[i]   <= '0;
            end
            alloc_q  <= '0;
            retire_q <= '0;
            count_q  <= '0;
        end else begin
            type_q   <= type_d;
            off_q    <= off_d;
            rd_num_q <= rd_num_d;
            rd_we_q  <= rd_we_d;
            killed_q <= killed_d;
            filled_q <= filled_d;
            fault_q  <= fault_d;
            data_q   <= data_d;
            alloc_q  <= alloc_d;
            retire_q <= retire_d;
            count_q  <= count_d;
        end
    end

    // A response with nothing waiting for it means the cache and this stage disagree.
    a_resp_expected: assert property (@(posedge clkrst_core_clk) disable iff (clkrst_core_rst)
                                      !(dc_resp_valid && !w_found));

endmodule
`default_nettype wire

// File: tb/tb_mcpu_core_stage_mem_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mcpu_core_stage_mem_pipe                                  |
// | Description : Directed bench for the memory stage with an in-order        |
// |               scoreboard of writeback results.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mcpu_core_stage_mem_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_ready;
    logic [31:0]       in_paddr, in_data;
    logic [3:0]        in_type;
    logic [4:0]        in_rd_num;
    logic              in_rd_we, flush;
    logic              dc_req_valid, dc_req_ready;
    logic [29:0]       dc_req_addr;
    logic [3:0]        dc_req_wmask;
    logic [31:0]       dc_req_wdata;
    logic              dc_resp_valid;
    logic [31:0]       dc_resp_data;
    logic              out_valid, out_ready;
    logic [31:0]       out_data;
    logic [4:0]        out_rd_num;
    logic              out_rd_we, out_fault;

    always #5 clk = ~clk;

    mcpu_core_stage_mem_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_W(RD_W)
    ) dut (
        .clkrst_core_clk(clk),
        .clkrst_core_rst(rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_paddr       (in_paddr),
        .in_data        (in_data),
        .in_type        (in_type),
        .in_rd_num      (in_rd_num),
        .in_rd_we       (in_rd_we),
        .flush          (flush),
        .dc_req_valid   (dc_req_valid),
        .dc_req_ready   (dc_req_ready),
        .dc_req_addr    (dc_req_addr),
        .dc_req_wmask   (dc_req_wmask),
        .dc_req_wdata   (dc_req_wdata),
        .dc_resp_valid  (dc_resp_valid),
        .dc_resp_data   (dc_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_rd_num     (out_rd_num),
        .out_rd_we      (out_rd_we),
        .out_fault      (out_fault)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_out(input logic [31:0] d, input logic [4:0] rd, input logic we,
                              input logic fault);
        exp_t e;
        e.data = d; e.rd = rd; e.we = we; e.fault = fault;
        exp_q.push_back(e);
    endtask

    // Monitor: every writeback handshake must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data",   out_data,   mon_e.data);
                check("out_rd_num", out_rd_num, mon_e.rd);
                check("out_rd_we",  out_rd_we,  mon_e.we);
                check("out_fault",  out_fault,  mon_e.fault);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, check the cache request.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] typ, input logic [4:0] rd, input logic we,
                          input logic exp_dcv, input logic [3:0] exp_mask,
                          input logic [31:0] exp_wdata);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_paddr = addr; in_data = data; in_type = typ;
        in_rd_num = rd; in_rd_we = we;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            check("req_accept_timeout", in_ready, 1'b1);
        end else begin
            check("dc_req_valid", dc_req_valid, exp_dcv);
            if (exp_dcv) begin
                check("dc_req_addr",  dc_req_addr,  addr >> 2);
                check("dc_req_wmask", dc_req_wmask, exp_mask);
                check("dc_req_wdata", dc_req_wdata, exp_wdata);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_resp(input logic [31:0] d);
        dc_resp_valid = 1'b1; dc_resp_data = d;
        @(posedge clk); #1;
        dc_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_paddr = '0; in_data = '0; in_type = '0;
        in_rd_num = '0; in_rd_we = 1'b0; flush = 1'b0; dc_req_ready = 1'b1;
        dc_resp_valid = 1'b0; dc_resp_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",     in_ready,     1'b0);
        check("rst_dc_req_valid", dc_req_valid, 1'b0);
        check("rst_out_valid",    out_valid,    1'b0);
        check("rst_out_fault",    out_fault,    1'b0);
        check("rst_out_data",     out_data,     32'h0);
        in_valid = 1'b0; rst = 1'b0;
        idle(1);

        // LW 0x100, result one cycle after the response.
        expect_out(32'hDEADBEEF, 5'd1, 1'b1, 1'b0);
        do_req(32'h100, 32'h0, 4'b0010, 5'd1, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'hDEADBEEF);
        @(negedge clk);
        check("lw_latency_out_valid", out_valid, 1'b1);
        idle(2);

        // Signed and unsigned byte loads from the top lane.
        expect_out(32'hFFFFFF80, 5'd2, 1'b1, 1'b0);
        do_req(32'h103, 32'h0, 4'b1000, 5'd2, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h80FFFFFF);
        expect_out(32'h00000080, 5'd3, 1'b1, 1'b0);
        do_req(32'h103, 32'h0, 4'b0000, 5'd3, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h80FFFFFF);
        idle(2);

        // Stores: lane mask / shifted data, write enable forced low on completion.
        expect_out(32'h0, 5'd4, 1'b0, 1'b0);
        do_req(32'h102, 32'h1234, 4'b0101, 5'd4, 1'b1, 1'b1, 4'b1100, 32'h12340000);
        do_resp(32'h0);
        expect_out(32'h0, 5'd5, 1'b0, 1'b0);
        do_req(32'h101, 32'hAB, 4'b0100, 5'd5, 1'b1, 1'b1, 4'b0010, 32'h0000AB00);
        do_resp(32'h0);
        expect_out(32'h0, 5'd6, 1'b0, 1'b0);
        do_req(32'h104, 32'hCAFEF00D, 4'b0110, 5'd6, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D);
        do_resp(32'h0);
        idle(2);

        // Halfword loads, and a doubleword treated as a word on a 32-bit cache.
        expect_out(32'hFFFF8001, 5'd7, 1'b1, 1'b0);
        do_req(32'h102, 32'h0, 4'b1001, 5'd7, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h80011234);
        expect_out(32'h00008765, 5'd8, 1'b1, 1'b0);
        do_req(32'h100, 32'h0, 4'b0001, 5'd8, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h12348765);
        expect_out(32'h0BADF00D, 5'd9, 1'b1, 1'b0);
        do_req(32'h108, 32'h0, 4'b1011, 5'd9, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h0BADF00D);
        idle(2);

        // Fill both entries with writeback stalled; the third must wait.
        out_ready = 1'b0;
        expect_out(32'h11111111, 5'd10, 1'b1, 1'b0);
        expect_out(32'h22222222, 5'd11, 1'b1, 1'b0);
        expect_out(32'h33333333, 5'd12, 1'b1, 1'b0);
        do_req(32'h200, 32'h0, 4'b0010, 5'd10, 1'b1, 1'b1, 4'h0, 32'h0);
        do_req(32'h204, 32'h0, 4'b0010, 5'd11, 1'b1, 1'b1, 4'h0, 32'h0);
        in_valid = 1'b1; in_paddr = 32'h208; in_type = 4'b0010; in_rd_num = 5'd12;
        @(negedge clk);
        check("full_in_ready",     in_ready,     1'b0);
        check("full_dc_req_valid", dc_req_valid, 1'b0);
        @(posedge clk); #1;
        do_resp(32'h11111111);
        do_resp(32'h22222222);
        @(negedge clk);
        check("held_out_valid", out_valid, 1'b1);
        check("held_in_ready",  in_ready,  1'b0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        do_req(32'h208, 32'h0, 4'b0010, 5'd12, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h33333333);
        idle(3);

        // Flush with two loads in flight: responses are drained, nothing written back.
        do_req(32'h300, 32'h0, 4'b0010, 5'd13, 1'b1, 1'b1, 4'h0, 32'h0);
        do_req(32'h304, 32'h0, 4'b0010, 5'd14, 1'b1, 1'b1, 4'h0, 32'h0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        do_resp(32'hAAAAAAAA);
        @(negedge clk);
        check("flush_out_valid_a", out_valid, 1'b0);
        @(posedge clk); #1;
        do_resp(32'hBBBBBBBB);
        @(negedge clk);
        check("flush_out_valid_b", out_valid, 1'b0);
        check("flush_drained_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        expect_out(32'h11223344, 5'd15, 1'b1, 1'b0);
        do_req(32'h200, 32'h0, 4'b0010, 5'd15, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'h11223344);
        @(negedge clk);
        check("post_flush_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;

        // Flush on an empty stage still blocks the incoming request.
        in_valid = 1'b1; in_paddr = 32'h400; in_type = 4'b0010; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready",     in_ready,     1'b0);
        check("flush_dc_req_valid", dc_req_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        idle(2);

        // Misaligned word after an aligned load.
        out_ready = 1'b0;
        expect_out(32'hCAFEBABE, 5'd16, 1'b1, 1'b0);
        do_req(32'h100, 32'h0, 4'b0010, 5'd16, 1'b1, 1'b1, 4'h0, 32'h0);
`ifdef MCPU_MEM_MISALIGN_FAULT_EN
        expect_out(32'h0, 5'd17, 1'b0, 1'b1);
        do_req(32'h101, 32'h0, 4'b0010, 5'd17, 1'b1, 1'b0, 4'h0, 32'h0);
        do_resp(32'hCAFEBABE);
`else
        expect_out(32'h5A5A5A5A, 5'd17, 1'b1, 1'b0);
        do_req(32'h101, 32'h0, 4'b0010, 5'd17, 1'b1, 1'b1, 4'h0, 32'h0);
        do_resp(32'hCAFEBABE);
        do_resp(32'h5A5A5A5A);
`endif
        out_ready = 1'b1;
        idle(6);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
